// File: rtl/uop_buf_ctrl.sv
// uop_buf_ctrl: control for a circular uop buffer held in an external RAM.
// Two producers (decoder A, microcode B) share one write port through a
// round-robin arbiter; one consumer pops the head entry. A flush request
// (clear) empties the buffer through a one-cycle-minimum FLUSH state.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   clear                 pipeline flush request
//   a_valid/a_uop/a_ready decoder producer handshake
//   b_valid/b_uop/b_ready microcode producer handshake
//   ram_we/ram_waddr/ram_wdata  write port to the uop RAM
//   ram_raddr             head address for the fetch stage
//   rd_valid/rd_take      consumer handshake on the head entry
//   count/full/empty      occupancy status
module uop_buf_ctrl #(
    parameter int UOP_BUF_SIZE  = 16,
    parameter int UOP_BUF_WIDTH = 72
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          a_valid,
    input  logic [UOP_BUF_WIDTH-1:0]      a_uop,
    output logic                          a_ready,
    input  logic                          b_valid,
    input  logic [UOP_BUF_WIDTH-1:0]      b_uop,
    output logic                          b_ready,
    output logic                          ram_we,
    output logic [$clog2(UOP_BUF_SIZE)-1:0] ram_waddr,
    output logic [UOP_BUF_WIDTH-1:0]      ram_wdata,
    output logic [$clog2(UOP_BUF_SIZE)-1:0] ram_raddr,
    output logic                          rd_valid,
    input  logic                          rd_take,
    output logic [$clog2(UOP_BUF_SIZE):0] count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(UOP_BUF_SIZE);
    localparam logic RUN   = 1'b0;
    localparam logic FLUSH = 1'b1;

    logic          state_q, state_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          last_b_q, last_b_d;
    logic          push_ok, push, pop, flush;

    assign count     = count_q;
    assign full      = count_q == (AW+1)'(UOP_BUF_SIZE);
    assign empty     = count_q == '0;
    assign ram_raddr = head_q;

    always_comb begin
        // reset gating keeps handshakes quiet while the synchronous reset is held
        push_ok   = !reset && state_q == RUN && !clear && !full;
        // A wins a conflict when B was granted last
        a_ready   = push_ok && a_valid && (!b_valid || last_b_q);
        b_ready   = push_ok && b_valid && !a_ready;
        push      = a_ready || b_ready;
        rd_valid  = !reset && state_q == RUN && !empty && !clear;
        pop       = rd_take && rd_valid;
        ram_we    = push;
        ram_waddr = tail_q;
        ram_wdata = a_ready ? a_uop : b_uop;
        state_d   = clear ? FLUSH : RUN;
        flush     = state_q == FLUSH;
        head_d    = flush ? '0 : head_q + AW'(pop);
        tail_d    = flush ? '0 : tail_q + AW'(push);
        count_d   = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        last_b_d  = push ? b_ready : last_b_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            last_b_q <= last_b_d;
        end
    end
endmodule

// File: tb/tb_uop_buf_ctrl.sv
// tb_uop_buf_ctrl: queue-based reference model plus read-data scoreboard for uop_buf_ctrl.
module tb_uop_buf_ctrl;
    localparam int N = 16;
    localparam int W = 72;

    logic         clk = 0;
    logic         reset = 1, clear = 0;
    logic         a_valid = 0, b_valid = 0, rd_take = 0;
    logic [W-1:0] a_uop = '0, b_uop = '0;
    logic         a_ready, b_ready, ram_we, rd_valid, full, empty;
    logic [3:0]   ram_waddr, ram_raddr;
    logic [W-1:0] ram_wdata;
    logic [4:0]   count;

    uop_buf_ctrl #(.UOP_BUF_SIZE(N), .UOP_BUF_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .a_valid(a_valid), .a_uop(a_uop), .a_ready(a_ready),
        .b_valid(b_valid), .b_uop(b_uop), .b_ready(b_ready),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .rd_valid(rd_valid), .rd_take(rd_take),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    // external uop RAM
    logic [W-1:0] mem [N];
    always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;

    // reference model: contents as a queue, write slot as a running index
    logic [W-1:0] mq [$];
    logic [W-1:0] exp_rd [$];
    int m_tail = 0;
    bit m_flush = 0, m_last_b = 1;
    bit e_rdv, e_elig, e_a, e_b;
    logic [W-1:0] e_d;

    always @(negedge clk) begin
        e_rdv  = !reset && !m_flush && !clear && mq.size() != 0;
        e_elig = !reset && !m_flush && !clear && mq.size() < N;
        e_a    = e_elig && a_valid && (!b_valid || m_last_b);
        e_b    = e_elig && b_valid && !e_a;
        e_d    = e_a ? a_uop : b_uop;
        chk("a_ready", W'(a_ready), W'(e_a));
        chk("b_ready", W'(b_ready), W'(e_b));
        chk("ram_we", W'(ram_we), W'(e_a || e_b));
        chk("rd_valid", W'(rd_valid), W'(e_rdv));
        chk("count", W'(count), W'(mq.size()));
        chk("full", W'(full), W'(mq.size() == N));
        chk("empty", W'(empty), W'(mq.size() == 0));
        chk("ram_raddr", W'(ram_raddr), W'((m_tail - mq.size() + N) % N));
        if (e_a || e_b) begin
            chk("ram_waddr", W'(ram_waddr), W'(m_tail));
            chk("ram_wdata", ram_wdata, e_d);
        end
        if (reset || m_flush) begin
            mq.delete();
            exp_rd.delete();
            m_tail = 0;
            if (reset) m_last_b = 1;
            m_flush = !reset && clear;
        end else if (clear) begin
            m_flush = 1;
        end else begin
            if (e_rdv && rd_take) void'(mq.pop_front());
            if (e_a || e_b) begin
                mq.push_back(e_d);
                exp_rd.push_back(e_d);
                m_tail = (m_tail + 1) % N;
                m_last_b = e_b;
            end
        end
    end

    // read-side monitor: whatever the DUT pops must be the oldest written uop
    always @(posedge clk) begin
        if (rd_valid && rd_take) begin
            if (exp_rd.size() == 0) chk("rd_underflow", W'(1), W'(0));
            else chk("rd_data", mem[ram_raddr], exp_rd.pop_front());
        end
    end

    function automatic logic [W-1:0] rnd_uop();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    task automatic step(input bit av, input bit bv, input bit tk, input bit cl, input bit rs);
        a_valid = av;
        b_valid = bv;
        rd_take = tk;
        clear   = cl;
        reset   = rs;
        a_uop   = rnd_uop();
        b_uop   = rnd_uop();
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 1);
        a_valid = 1; reset = 0; a_uop = 72'h11;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (4) step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (17) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        repeat (20) step(1, 0, 1, 0, 0);
        repeat (4) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (5) step(1, 0, 0, 0, 0);
        repeat (2) step(1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        repeat (7) step(0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 1);
        repeat (3) step(1, 1, 0, 0, 0);
        repeat (2000)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 99) < 4, $urandom_range(0, 199) == 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
